// File: rtl/seg_scan_arbiter.sv
// Three-requester arbiter for an 8-digit multiplexed 7-segment display.
// Optional macro SEG_BLANK_SWITCH_EN inserts one blank frame on every owner-to-owner switch.
module seg_scan_arbiter #(
   parameter int unsigned HOLD_FRAMES = 4
) (
   input  logic        R_clk_1000HZ,
   input  logic        I_rst,
   input  logic [2:0]  I_req,
   input  logic [31:0] I_data0,
   input  logic [31:0] I_data1,
   input  logic [31:0] I_data2,
   output logic [7:0]  O_shift,
   output logic [6:0]  O_data,
   output logic [2:0]  O_grant,
   output logic        O_busy
);

   localparam int unsigned CntW = $clog2(HOLD_FRAMES + 2);
   localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_FRAMES);

   typedef enum logic [1:0] {
      StIdle,
`ifdef SEG_BLANK_SWITCH_EN
      StScan,
      StBlank
`else
      StScan
`endif
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [31:0]     data_q, data_d;
   logic [2:0]      owner_q, owner_d;
   logic [2:0]      higher, new_owner;
   logic            do_switch;
   logic [7:0]      shift_q, shift_d;
   logic [6:0]      seg_q, seg_d;
   logic [2:0]      grant_q, grant_d;
   logic            busy_q, busy_d;

   function automatic logic [2:0] pick_hi(input logic [2:0] req);
      if (req[2]) return 3'b100;
      else if (req[1]) return 3'b010;
      else if (req[0]) return 3'b001;
      else return 3'b000;
   endfunction

   function automatic logic [31:0] sel_data(input logic [2:0] g, input logic [31:0] d0,
                                            input logic [31:0] d1, input logic [31:0] d2);
      case (g)
         3'b100:  return d2;
         3'b010:  return d1;
         default: return d0;
      endcase
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      case (nib)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      owner_d   = owner_q;
      new_owner = owner_q;
      do_switch = 1'b0;
      cnt_inc   = (cnt_q >= HoldMax) ? cnt_q : cnt_q + 1'b1;
      case (owner_q)
         3'b001:  higher = I_req & 3'b110;
         3'b010:  higher = I_req & 3'b100;
         default: higher = 3'b000;
      endcase

      case (state_q)
         StIdle: begin
            if (|I_req) begin
               owner_d = pick_hi(I_req);
               data_d  = sel_data(owner_d, I_data0, I_data1, I_data2);
               idx_d   = 3'd0;
               cnt_d   = '0;
               state_d = StScan;
            end
         end
         StScan: begin
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
               if ((owner_q & I_req) == 3'b000) begin
                  if (I_req == 3'b000) begin
                     state_d = StIdle;
                     owner_d = 3'b000;
                     cnt_d   = '0;
                  end else begin
                     new_owner = pick_hi(I_req);
                     do_switch = 1'b1;
                  end
               end else if ((|higher) && (cnt_inc >= HoldMax)) begin
                  new_owner = pick_hi(higher);
                  do_switch = 1'b1;
               end else begin
                  // Same owner keeps the display; refresh its data at the frame start.
                  cnt_d  = cnt_inc;
                  data_d = sel_data(owner_q, I_data0, I_data1, I_data2);
               end
               if (do_switch) begin
                  owner_d = new_owner;
                  cnt_d   = '0;
`ifdef SEG_BLANK_SWITCH_EN
                  state_d = StBlank;
`else
                  data_d  = sel_data(new_owner, I_data0, I_data1, I_data2);
`endif
               end
            end
         end
`ifdef SEG_BLANK_SWITCH_EN
         StBlank: begin
            // owner_q holds the pending grant; requests are ignored until the frame ends.
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
               state_d = StScan;
               data_d  = sel_data(owner_q, I_data0, I_data1, I_data2);
            end
         end
`endif
         default: begin
            state_d = StIdle;
            owner_d = 3'b000;
            idx_d   = 3'd0;
            cnt_d   = '0;
         end
      endcase

      // Outputs are registered from next-state values so they track the state exactly.
      shift_d = 8'hFF;
      seg_d   = 7'h7F;
      grant_d = 3'b000;
      busy_d  = (state_d != StIdle);
      if (state_d == StScan) begin
         shift_d = ~(8'h01 << idx_d);
         seg_d   = seg_decode(data_d[{idx_d, 2'b00} +: 4]);
         grant_d = owner_d;
      end
   end

   always_ff @(posedge R_clk_1000HZ) begin
      if (I_rst) begin
         state_q <= StIdle;
         idx_q   <= 3'd0;
         cnt_q   <= '0;
         data_q  <= 32'hBBBBBBBB;
         owner_q <= 3'b000;
         shift_q <= 8'hFF;
         seg_q   <= 7'h7F;
         grant_q <= 3'b000;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         owner_q <= owner_d;
         shift_q <= shift_d;
         seg_q   <= seg_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
      end
   end

   assign O_shift = shift_q;
   assign O_data  = seg_q;
   assign O_grant = grant_q;
   assign O_busy  = busy_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Directed self-checking bench for seg_scan_arbiter (HOLD_FRAMES = 4).
// Blank-frame expectations are enabled when SEG_BLANK_SWITCH_EN is defined.
module tb_seg_scan_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [31:0] data0, data1, data2;
   logic [7:0]  o_shift;
   logic [6:0]  o_data;
   logic [2:0]  o_grant;
   logic        o_busy;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   seg_scan_arbiter #(
      .HOLD_FRAMES(4)
   ) u_dut (
      .R_clk_1000HZ(clk),
      .I_rst       (rst),
      .I_req       (req),
      .I_data0     (data0),
      .I_data1     (data1),
      .I_data2     (data2),
      .O_shift     (o_shift),
      .O_data      (o_data),
      .O_grant     (o_grant),
      .O_busy      (o_busy)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no summary, required finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] seg_ref(input logic [3:0] nib);
      case (nib)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic check_idle(input string tag);
      check_eq({tag, " shift"}, o_shift, 8'hFF);
      check_eq({tag, " data"}, o_data, 7'h7F);
      check_eq({tag, " grant"}, o_grant, 3'b000);
      check_eq({tag, " busy"}, o_busy, 1'b0);
   endtask

   // Checks digits first..7 of the current frame, ticking after each one.
   task automatic check_digits(input string tag, input int first, input logic [2:0] g,
                               input logic [31:0] word);
      for (int d = first; d < 8; d++) begin
         logic [7:0] sh;
         logic [3:0] nib;
         sh  = ~(8'h01 << d);
         nib = word[d*4 +: 4];
         check_eq($sformatf("%s d%0d shift", tag, d), o_shift, sh);
         check_eq($sformatf("%s d%0d data", tag, d), o_data, seg_ref(nib));
         check_eq($sformatf("%s d%0d grant", tag, d), o_grant, g);
         check_eq($sformatf("%s d%0d busy", tag, d), o_busy, 1'b1);
         tick();
      end
   endtask

`ifdef SEG_BLANK_SWITCH_EN
   task automatic check_blank(input string tag);
      for (int d = 0; d < 8; d++) begin
         check_eq($sformatf("%s b%0d shift", tag, d), o_shift, 8'hFF);
         check_eq($sformatf("%s b%0d data", tag, d), o_data, 7'h7F);
         check_eq($sformatf("%s b%0d grant", tag, d), o_grant, 3'b000);
         check_eq($sformatf("%s b%0d busy", tag, d), o_busy, 1'b1);
         tick();
      end
   endtask
`endif

   task automatic do_reset();
      rst = 1'b1;
      req = 3'b000;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_shift [8];
      logic [6:0] exp_seg [8];
      exp_shift = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      exp_seg   = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

      rst   = 1'b1;
      req   = 3'b000;
      data0 = 32'hBBBB1234;
      data1 = 32'h98765432;
      data2 = 32'h00000089;
      tick();
      tick();
      check_idle("reset");
      rst = 1'b0;
      tick();
      check_idle("idle_no_req");

      // Basic scan of requester 0, two frames.
      req = 3'b001;
      tick();
      for (int f = 0; f < 2; f++) begin
         for (int d = 0; d < 8; d++) begin
            check_eq($sformatf("basic f%0d d%0d shift", f, d), o_shift, exp_shift[d]);
            check_eq($sformatf("basic f%0d d%0d data", f, d), o_data, exp_seg[d]);
            check_eq($sformatf("basic f%0d d%0d grant", f, d), o_grant, 3'b001);
            tick();
         end
      end

      // Higher-priority preemption after the hold time, then no lower-priority preemption.
      do_reset();
      req = 3'b001;
      tick();
      req = 3'b011;
      for (int f = 1; f <= 4; f++) check_digits($sformatf("hold f%0d", f), 0, 3'b001, data0);
`ifdef SEG_BLANK_SWITCH_EN
      check_blank("hold_sw");
`endif
      check_digits("preempt", 0, 3'b010, data1);
      check_digits("no_low_preempt", 0, 3'b010, data1);
      req = 3'b001;
      check_digits("drop_finish", 0, 3'b010, data1);
`ifdef SEG_BLANK_SWITCH_EN
      check_blank("drop_sw");
`endif
      check_digits("fallback", 0, 3'b001, data0);

      // Simultaneous requests: highest wins.
      do_reset();
      data0 = 32'h76543210;
      req   = 3'b101;
      tick();
      check_digits("simul", 0, 3'b100, data2);

      // Owner drops at digit 3: frame completes, then idle.
      do_reset();
      req = 3'b001;
      tick();
      tick();
      tick();
      tick();
      req = 3'b000;
      check_digits("drop", 3, 3'b001, 32'h76543210);
      check_idle("drop_idle");

      // Mid-frame data change is deferred to the next frame.
      do_reset();
      data0 = 32'h01234567;
      req   = 3'b001;
      tick();
      tick();
      tick();
      data0 = 32'hFEDCBA98;
      check_digits("mid_data_old", 2, 3'b001, 32'h01234567);
      check_digits("mid_data_new", 0, 3'b001, 32'hFEDCBA98);

      // Reset mid-frame overrides an active request.
      tick();
      tick();
      rst = 1'b1;
      tick();
      check_idle("mid_reset");
      rst = 1'b0;
      tick();
      check_eq("post_reset grant", o_grant, 3'b001);
      check_eq("post_reset shift", o_shift, 8'hFE);
      check_eq("post_reset data", o_data, seg_ref(4'h8));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seg_scan_arbiter.md
SEG_SCAN_ARBITER -- requirements
Module: seg_scan_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_FRAMES, default 4: the minimum number of complete frames an owner keeps the display before a higher-priority requester may preempt it.
REQ-002 Port R_clk_1000HZ, input, 1: digit scan clock; the only clock.
REQ-003 Port I_rst, input, 1: synchronous active-high reset.
REQ-004 Port I_req, input, 3: display requests; bit 2 is highest priority, bit 0 is lowest.
REQ-005 Ports I_data0, I_data1 and I_data2, input, 32 each: per-requester digit codes; nibble k drives digit k.
REQ-006 Port O_shift, output, 8: active-low one-hot digit select.
REQ-007 Port O_data, output, 7: active-low segments, gfedcba.
REQ-008 Port O_grant, output, 3: one-hot current owner; 000 means no owner.
REQ-009 Port O_busy, output, 1: high whenever the state is not IDLE.

Function
REQ-010 States SHALL be IDLE, SCAN and BLANK; BLANK is present only per REQ-030.
REQ-011 All outputs SHALL be registered and SHALL change only on the rising edge of R_clk_1000HZ.
REQ-012 In IDLE, the outputs SHALL be O_shift=8'hFF, O_data=7'h7F, O_grant=000 and O_busy=0.
REQ-013 In IDLE, when I_req is nonzero at an edge, the block SHALL grant the highest-priority set bit, latch that requester's 32-bit data, and enter SCAN.
REQ-014 One cycle after the IDLE-exit edge, the block SHALL present O_grant and digit 0: O_shift=8'hFE.
REQ-015 In SCAN, the digit index SHALL advance by 1 every cycle over 0..7 and wrap 7->0; O_shift SHALL have only bit[index] low.
REQ-016 One frame SHALL be 8 consecutive digit cycles, index 0 through 7.
REQ-017 Owner data SHALL be latched only at a frame start; input changes mid-frame SHALL NOT be visible until the next frame.
REQ-018 Nibble decode SHALL use hex codes 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10; codes 10-15 SHALL decode to 7F (blank).
REQ-019 The frame counter SHALL increment at each frame boundary (end of digit 7), saturate at HOLD_FRAMES, and clear on every ownership change.
REQ-020 Ownership SHALL be re-evaluated only at frame boundaries; there SHALL be no mid-frame switching.
REQ-021 At a boundary with the owner's request low, the block SHALL grant the highest remaining requester, or go to IDLE if I_req=000.
REQ-022 At a boundary with the owner's request high, the block SHALL switch to a higher-priority requester only if the frame counter is at least HOLD_FRAMES.
REQ-023 A lower-priority request SHALL never preempt an owner whose request is still high.
REQ-024 If the owner drops its request mid-frame, the block SHALL complete the frame with the latched data, then apply REQ-021.
REQ-025 A switch SHALL relatch data from the new owner and restart at digit 0 in the next cycle; O_grant SHALL update in that same cycle.
REQ-026 When several requests rise simultaneously, REQ-013 and REQ-021 priority SHALL resolve the grant.

Reset
REQ-027 While I_rst=1 at an edge, the next state SHALL be IDLE, the digit index 0, the frame counter 0, and the latched data 32'hBBBBBBBB.
REQ-028 After reset, outputs SHALL be as in REQ-012.
REQ-029 Reset asserted mid-frame SHALL abort the frame, with reset values visible on the following cycle; I_rst SHALL override all requests.

Configuration
REQ-030 With macro SEG_BLANK_SWITCH_EN defined, every owner-to-owner switch SHALL insert one BLANK frame before SCAN resumes.
REQ-031 A BLANK frame SHALL last 8 cycles with O_shift=8'hFF, O_data=7'h7F, O_grant=000 and O_busy=1.
REQ-032 During BLANK the pending grant SHALL be held fixed and requests SHALL be ignored; SCAN SHALL then resume at digit 0 with the new owner.
REQ-033 A switch to IDLE SHALL never insert a BLANK frame.
REQ-034 Without SEG_BLANK_SWITCH_EN, the BLANK state SHALL be absent and REQ-025 timing SHALL apply.

Verification
REQ-035 Reset, then I_req=001 with I_data0=32'hBBBB1234 -> next cycle O_grant=001, O_shift=FE, O_data=19; then FD/30, FB/24, F7/79, EF/7F; digits 5-7 also 7F; the frame repeats.
REQ-036 With req0 owning, raise req1 during frame 1 (HOLD_FRAMES=4) -> O_grant stays 001 through the end of frame 4, then becomes 010 at digit 0.
REQ-037 From IDLE, raise I_req=101 on one edge -> O_grant=100 and data comes from I_data2.
REQ-038 Owner drops its request at digit 3 -> digits 4-7 still shown from the latched data, then IDLE with FF/7F, grant 000, busy 0.
REQ-039 Change I_data0 at digit 2 -> digits 2-7 of that frame are unchanged; the new value appears from the next digit 0.
REQ-040 With SEG_BLANK_SWITCH_EN defined, a req0->req2 switch -> 8 cycles of FF/7F with grant 000, then grant 100 and O_shift=FE.
